// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: the CPU owns the single memory port by default;
// a loader/debug master is served when the CPU is idle, or forced in after
// MAX_WAIT consecutive denied cycles at the cost of a one-cycle CPU stall.
module dm_port_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    // CPU datapath side
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    // Loader / debug master side
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic              ld_ack,
    output logic [31:0]       ld_rdata,
    // Data memory side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    // Statistics
    output logic [15:0]       stall_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);
    // Clears the two byte-offset bits so the memory only ever sees word addresses.
    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  wait_cnt;
    logic [3:0]  wait_cnt_nxt;
    logic        ld_grant;
    logic        cpu_grant;
    logic        wait_expired;

    // Saturating 16-bit increment for the stall statistics counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF)
            return v;
        else
            return v + 16'd1;
    endfunction

    // Bounded increment for the loader wait counter; never passes the limit.
    function automatic logic [3:0] wait_inc(input logic [3:0] v, input logic [3:0] lim);
        if (v >= lim)
            return lim;
        else
            return v + 4'd1;
    endfunction

    assign wait_expired = (wait_cnt >= WAIT_LIMIT);

    // Grant decision, memory mux and FSM next state; loader wins only in IDLE.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        ld_grant     = 1'b0;
        cpu_grant    = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        ld_grant  = ~rst && (state == IDLE) && ld_req && (~cpu_req || wait_expired);
        cpu_grant = cpu_req && ~ld_grant;

        if (ld_grant) begin
            mem_en    = 1'b1;
            mem_we    = ld_we;
            mem_addr  = ld_addr & WORD_MASK;
            mem_wdata = ld_wdata;
        end else if (cpu_grant) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr & WORD_MASK;
            mem_wdata = cpu_wdata;
        end

        if (ld_grant || ~ld_req)
            wait_cnt_nxt = 4'd0;
        else if ((state == IDLE) && ld_req && cpu_req)
            wait_cnt_nxt = wait_inc(wait_cnt, WAIT_LIMIT);

        case (state)
            IDLE:    if (ld_grant) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign cpu_stall = cpu_req && ld_grant;
    assign cpu_rdata = mem_rdata;

    // State register and wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Loader acknowledge pulse and read-data capture on the grant edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_ack   <= 1'b0;
            ld_rdata <= 32'd0;
        end else begin
            ld_ack <= ld_grant;
            if (ld_grant && ~ld_we)
                ld_rdata <= mem_rdata;
        end
    end

    // Count every cycle the CPU is held off, saturating at full scale.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= 16'd0;
        else if (cpu_stall)
            stall_cnt <= sat_inc16(stall_cnt);
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed testbench for dm_port_arbiter with a small word-addressed memory model.
module tb_dm_port_arbiter;

    localparam int ADDR_W   = 12;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata, cpu_rdata;
    logic              cpu_stall;
    logic              ld_req, ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       ld_wdata;
    logic              ld_ack;
    logic [31:0]       ld_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;
    logic [15:0]       stall_cnt;

    int checks = 0;
    int errors = 0;
    int exp_sc;

    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    // Memory model: combinational read, write on the rising edge.
    assign mem_rdata = mem[mem_addr[11:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;

    dm_port_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ack(ld_ack), .ld_rdata(ld_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;

        // Reset held two cycles with both masters requesting
        rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010; cpu_wdata = 32'd0;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 12'h020; ld_wdata = 32'd0;
        tick(); tick();
        chk("rst_ld_ack", 32'(ld_ack), 32'd0);
        chk("rst_ld_rdata", ld_rdata, 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h010);
        rst = 1'b0; ld_req = 1'b0; cpu_req = 1'b0;
        tick();

        // CPU store then load
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h014; cpu_wdata = 32'h12345678;
        #1;
        chk("cpu_st_we", 32'(mem_we), 32'd1);
        chk("cpu_st_addr", 32'(mem_addr), 32'h014);
        chk("cpu_st_stall", 32'(cpu_stall), 32'd0);
        tick();
        cpu_we = 1'b0;
        #1;
        chk("cpu_ld_data", cpu_rdata, 32'h12345678);
        chk("cpu_ld_stall", 32'(cpu_stall), 32'd0);
        tick();

        // Misaligned CPU address is word-aligned at the memory
        cpu_addr = 12'h017;
        #1;
        chk("align_addr", 32'(mem_addr), 32'h014);
        chk("align_data", cpu_rdata, 32'h12345678);
        tick();
        cpu_req = 1'b0;

        // Loader write with CPU idle
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 12'h01C; ld_wdata = 32'hDEADBEEF;
        #1;
        chk("ldw_we", 32'(mem_we), 32'd1);
        chk("ldw_addr", 32'(mem_addr), 32'h01C);
        chk("ldw_wdata", mem_wdata, 32'hDEADBEEF);
        chk("ldw_ack_early", 32'(ld_ack), 32'd0);
        tick();
        chk("ldw_ack", 32'(ld_ack), 32'd1);
        chk("ldw_ack_cycle_en", 32'(mem_en), 32'd0);
        ld_req = 1'b0;
        tick();
        chk("ldw_ack_drop", 32'(ld_ack), 32'd0);

        // Loader read of the same word
        ld_req = 1'b1; ld_we = 1'b0;
        #1;
        chk("ldr_en", 32'(mem_en), 32'd1);
        chk("ldr_we", 32'(mem_we), 32'd0);
        tick();
        chk("ldr_ack", 32'(ld_ack), 32'd1);
        chk("ldr_data", ld_rdata, 32'hDEADBEEF);
        ld_req = 1'b0;
        tick();
        chk("ldr_ack_drop", 32'(ld_ack), 32'd0);
        chk("ldr_data_hold", ld_rdata, 32'hDEADBEEF);

        // Forced grant and back-to-back loader requests under continuous CPU loads
        exp_sc = 0;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) tick();
            if (k == 0) begin
                cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h014;
                ld_req = 1'b1; ld_we = 1'b0; ld_addr = 12'h01C;
            end
            #1;
            chk($sformatf("b2b_stall_%0d", k), 32'(cpu_stall), 32'((k % 6) == 4));
            chk($sformatf("b2b_ack_%0d", k), 32'(ld_ack), 32'((k == 5) || (k == 11)));
            chk($sformatf("b2b_addr_%0d", k), 32'(mem_addr), ((k % 6) == 4) ? 32'h01C : 32'h014);
            chk($sformatf("b2b_scnt_%0d", k), 32'(stall_cnt), 32'(exp_sc));
            if ((k % 6) == 4) exp_sc++;
            if (k == 5) chk("forced_cpu_data", cpu_rdata, 32'h12345678);
        end

        // Reset while a wait is pending clears the wait counter
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("rstw_stall", 32'(cpu_stall), 32'd0);
        tick();
        chk("rstw_scnt", 32'(stall_cnt), 32'd0);
        rst = 1'b0;
        for (int j = 0; j <= 4; j++) begin
            if (j > 0) tick();
            #1;
            chk($sformatf("rstw_stall_%0d", j), 32'(cpu_stall), 32'(j == 4));
        end

        // Reset during the ACK cycle drops the acknowledge
        tick();
        chk("ack_before_rst", 32'(ld_ack), 32'd1);
        rst = 1'b1; ld_req = 1'b0; cpu_req = 1'b0;
        tick();
        chk("rsta_ack", 32'(ld_ack), 32'd0);
        chk("rsta_rdata", ld_rdata, 32'd0);
        chk("rsta_scnt", 32'(stall_cnt), 32'd0);
        rst = 1'b0;
        tick();
        chk("rsta_ack_after", 32'(ld_ack), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
